// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone B3 classic arbiter in front of a single slave port.
// m0 is the CPU bus, m1 the DMA/debug master. One master owns the slave per transfer;
// every transfer is followed by one IDLE cycle in which arbitration happens again.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort transfers after TO_CYCLES cycles
// without ack/err and expose the sticky to_flag_o output.
module wb_arbiter_2m #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    // master 0 (CPU)
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // master 1 (DMA/debug)
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // shared slave port
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    // registered one-hot grant {m1,m0}
    output logic [1:0]      gnt_o
`ifdef WB_ARB_TIMEOUT_EN
    ,
    output logic            to_flag_o
`endif
);

    localparam int unsigned SW = DW / 8;

    if (TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_to_range
        $error("wb_arbiter_2m: TO_CYCLES must be within 1..65535");
    end

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t state_q;
    logic   own_q;   // 0 = m0 owns the slave, 1 = m1
    logic   last_q;  // master served by the previous transfer

    logic   req0;
    logic   req1;
    logic   win_c;
    logic   busy;
    logic   own_cyc;
    logic   own_stb;
    logic   to_hit;
    logic   done_c;

    // Request decode and winner selection for the next IDLE cycle
    always_comb begin
        req0  = m0_cyc_i & m0_stb_i;
        req1  = m1_cyc_i & m1_stb_i;
        win_c = 1'b0;
        if (req0 && req1) begin
            win_c = (PRIO_MODE == 1) ? 1'b0 : ~last_q;
        end else begin
            win_c = req1;
        end
    end

    // Owner handshake view and end-of-transfer detection
    always_comb begin
        busy    = (state_q == ST_BUSY);
        own_cyc = own_q ? m1_cyc_i : m0_cyc_i;
        own_stb = own_q ? m1_stb_i : m0_stb_i;
        done_c  = busy & ((own_stb & (s_ack_i | s_err_i)) | ~own_cyc | to_hit);
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

    logic [15:0] to_cnt_q;

    // Watchdog fires in the BUSY cycle whose count equals TO_CYCLES-1 (the TO_CYCLES-th cycle)
    always_comb begin
        to_hit = busy & ~(s_ack_i | s_err_i) & (to_cnt_q == TO_LAST);
    end

    // Watchdog counter (held at zero while IDLE) and sticky timeout flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q  <= '0;
            to_flag_o <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                to_cnt_q <= '0;
            end else if (!(s_ack_i | s_err_i)) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
            if (to_hit) begin
                to_flag_o <= 1'b1;
            end
        end
    end
`else
    // No watchdog: a BUSY transfer waits indefinitely for ack/err or a cyc drop
    always_comb begin
        to_hit = 1'b0;
    end
`endif

    // Arbitration FSM with registered owner, last-served and grant
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            own_q   <= 1'b0;
            last_q  <= 1'b0;
            gnt_o   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        own_q   <= win_c;
                        gnt_o   <= win_c ? 2'b10 : 2'b01;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_c) begin
                        last_q  <= own_q;
                        gnt_o   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_o   <= '0;
                end
            endcase
        end
    end

    // Slave-side mux and owner-only ack/err return; everything zero while IDLE
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        if (busy) begin
            s_cyc_o = own_cyc & ~to_hit;
            s_stb_o = own_cyc & own_stb & ~to_hit;
            if (own_q) begin
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | to_hit;
            end else begin
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | to_hit;
            end
        end
    end

    logic [SW-1:0] sel_width_ref;
    always_comb begin
        sel_width_ref = s_sel_o;
    end

endmodule
